// File: rtl/ivl_uvm_rr_arbiter.sv
// ivl_uvm_rr_arbiter
//   Registered round-robin arbiter sharing one resource among NUM_REQ
//   requesters. The owner keeps the grant while it requests. It is forced
//   to rotate after MAX_HOLD consecutive cycles if someone else is waiting
//   (MAX_HOLD=0 disables the limit).
//
// Parameters
//   NUM_REQ   number of requesters (2..16)
//   MAX_HOLD  hold limit before forced rotation, 0 = unlimited
//   GW        width of gnt_id (derived, do not override)
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_vec      request level per requester
//   arb_gnt_vec  registered grant, one-hot or zero
//   gnt_valid    |arb_gnt_vec
//   gnt_id       index of current grantee, holds when no grant
//   preempt      pulse in the first cycle of a hold-limit rotation grant
//   hold_cnt     cycles the current grant has been held (saturating)
module ivl_uvm_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_vec,
    output logic [NUM_REQ-1:0] arb_gnt_vec,
    output logic               gnt_valid,
    output logic [GW-1:0]      gnt_id,
    output logic               preempt,
    output logic [4:0]         hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [4:0]    HOLD_SAT = (MAX_HOLD == 0) ? 5'd31 : 5'(MAX_HOLD);
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]        id_q, id_d;
    logic [GW-1:0]        last_q, last_d;
    logic [4:0]           hold_q, hold_d;
    logic                 pre_q, pre_d;
    logic [NUM_REQ-1:0]   others;
    logic [GW-1:0]        nxt;

    // First requesting index scanning start, start+1, ... modulo NUM_REQ.
    // start may equal NUM_REQ (o+1 with o at the top), so one wrap suffices.
    // Scanning offsets high-to-low lets the smallest offset win.
    function automatic logic [GW-1:0] find_next(input logic [NUM_REQ-1:0] req,
                                                input int start);
        logic [GW-1:0] idx;
        int j;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = start + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[GW'(j)]) idx = GW'(j);
        end
        return idx;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= LAST_RST;
            hold_q  <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            pre_q   <= pre_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        hold_d  = hold_q;
        pre_d   = 1'b0;
        nxt     = '0;
        // Pending requests other than the current owner.
        others  = req_vec & ~gnt_q;

        unique case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    nxt     = find_next(req_vec, int'(last_q) + 1);
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << nxt;
                    id_d    = nxt;
                    last_d  = nxt;
                    hold_d  = 5'd1;
                end
            end
            GRANT: begin
                if (!req_vec[id_q]) begin
                    if (|others) begin
                        // Direct handover, no idle cycle in between.
                        nxt    = find_next(req_vec, int'(id_q) + 1);
                        gnt_d  = NUM_REQ'(1) << nxt;
                        id_d   = nxt;
                        last_d = nxt;
                        hold_d = 5'd1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        hold_d  = 5'd0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q >= HOLD_SAT) && (|others)) begin
                    // Owner still requests, but a waiter exists, so the scan
                    // from o+1 reaches the waiter before wrapping back to o.
                    nxt    = find_next(req_vec, int'(id_q) + 1);
                    gnt_d  = NUM_REQ'(1) << nxt;
                    id_d   = nxt;
                    last_d = nxt;
                    hold_d = 5'd1;
                    pre_d  = 1'b1;
                end else begin
                    hold_d = (hold_q >= HOLD_SAT) ? HOLD_SAT : hold_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs (all driven straight from registers)
    always_comb begin
        arb_gnt_vec = gnt_q;
        gnt_valid   = |gnt_q;
        gnt_id      = id_q;
        preempt     = pre_q;
        hold_cnt    = hold_q;
    end

endmodule
